// File: rtl/fml_wb_bridge_pkg.sv
// fml_wb_bridge_pkg: shared state encoding and lane constant for the Wishbone-to-FML bridge
package fml_wb_bridge_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, ACK = 2'd3} state_t;
  localparam logic LANE_HI = 1'b0;
endpackage

// File: rtl/fml_wb_merge.sv
// fml_wb_merge: places a 32-bit write into its 64-bit lane and merges enabled bytes over old data
module fml_wb_merge
  import fml_wb_bridge_pkg::*;
(
  input  logic [63:0] i_old,
  input  logic [31:0] i_new,
  input  logic [3:0]  i_sel,
  input  logic        i_lane,
  output logic [63:0] o_data,
  output logic [7:0]  o_sel
);
  logic [63:0] w_new;
  assign w_new = {i_new, i_new};
  assign o_sel = (i_lane == LANE_HI) ? {i_sel, 4'h0} : {4'h0, i_sel};
  for (genvar b = 0; b < 8; b++) begin : g_byte
    assign o_data[8*b +: 8] = o_sel[b] ? w_new[8*b +: 8] : i_old[8*b +: 8];
  end
endmodule

// File: rtl/fml_wb_bridge.sv
// fml_wb_bridge: 32-bit Wishbone classic to 64-bit FML bridge with a one-entry write-through read buffer
module fml_wb_bridge
  import fml_wb_bridge_pkg::*;
#(
  parameter int adr_width = 30
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  output logic                 wb_ack_o,
  output logic [adr_width-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  output logic [7:0]           fml_sel,
  output logic [63:0]          fml_dw,
  input  logic [63:0]          fml_dr,
  input  logic                 fml_ack,
  input  logic                 inv
);
  state_t               r_state;
  logic                 r_valid;
  logic                 r_abort;
  logic                 r_lane;
  logic [3:0]           r_wsel;
  logic [adr_width-4:0] r_tag;
  logic [63:0]          r_data;
  logic                 w_idle;
  logic                 w_lane;
  logic [31:0]          w_new;
  logic [3:0]           w_sel4;
  logic [63:0]          w_merged;
  logic [7:0]           w_sel8;
  logic                 w_hit;
  logic                 w_whit;
  logic [31:0]          w_buf_half;
  logic [31:0]          w_dr_half;
  state_t               w_done_st;
  logic                 w_unused;
  assign w_unused = ^{wb_adr_i[31:adr_width], wb_adr_i[1:0]};
  // In IDLE the merger builds fml_sel from the live request; afterwards it merges the latched write
  assign w_idle     = (r_state == IDLE);
  assign w_lane     = w_idle ? wb_adr_i[2] : r_lane;
  assign w_new      = w_idle ? wb_dat_i : fml_dw[31:0];
  assign w_sel4     = w_idle ? wb_sel_i : r_wsel;
  assign w_hit      = r_valid && (r_tag == wb_adr_i[adr_width-1:3]);
  assign w_whit     = r_valid && (r_tag == fml_adr[adr_width-1:3]);
  assign w_buf_half = (wb_adr_i[2] == LANE_HI) ? r_data[63:32] : r_data[31:0];
  assign w_dr_half  = (r_lane == LANE_HI) ? fml_dr[63:32] : fml_dr[31:0];
  assign w_done_st  = (r_abort || !wb_cyc_i) ? IDLE : ACK;
  fml_wb_merge u_merge (
    .i_old (r_data),
    .i_new (w_new),
    .i_sel (w_sel4),
    .i_lane(w_lane),
    .o_data(w_merged),
    .o_sel (w_sel8)
  );
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_abort  <= 1'b0;
      r_lane   <= 1'b0;
      r_wsel   <= '0;
      r_tag    <= '0;
      r_data   <= '0;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      fml_adr  <= '0;
      fml_stb  <= 1'b0;
      fml_we   <= 1'b0;
      fml_sel  <= '0;
      fml_dw   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            if (!wb_we_i && w_hit) begin
              r_state  <= ACK;
              wb_ack_o <= 1'b1;
              wb_dat_o <= w_buf_half;
            end else begin
              r_state <= wb_we_i ? WR : RD;
              r_abort <= 1'b0;
              r_lane  <= wb_adr_i[2];
              r_wsel  <= wb_sel_i;
              fml_stb <= 1'b1;
              fml_we  <= wb_we_i;
              fml_adr <= {wb_adr_i[adr_width-1:3], 3'b000};
              fml_sel <= wb_we_i ? w_sel8 : 8'hFF;
              fml_dw  <= {wb_dat_i, wb_dat_i};
            end
          end
        end
        RD, WR: begin
          if (!wb_cyc_i) r_abort <= 1'b1;
          if (fml_ack) begin
            fml_stb  <= 1'b0;
            r_state  <= w_done_st;
            wb_ack_o <= (w_done_st == ACK);
            if (r_state == RD) begin
              r_data   <= fml_dr;
              r_tag    <= fml_adr[adr_width-1:3];
              r_valid  <= 1'b1;
              wb_dat_o <= w_dr_half;
            end else if (w_whit) begin
              r_data <= w_merged;
            end
          end
        end
        default: begin
          wb_ack_o <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
      // Invalidate overrides any fill or merge in the same cycle
      if (inv) r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fml_wb_bridge.sv
// tb_fml_wb_bridge: directed scoreboard bench with a latency-configurable FML slave model
module tb_fml_wb_bridge;
  localparam int AW = 30;
  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [31:0]   wb_adr_i = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel_i = '0;
  logic          wb_cyc_i = 1'b0;
  logic          wb_stb_i = 1'b0;
  logic          wb_we_i = 1'b0;
  logic          wb_ack_o;
  logic [AW-1:0] fml_adr;
  logic          fml_stb;
  logic          fml_we;
  logic [7:0]    fml_sel;
  logic [63:0]   fml_dw;
  logic [63:0]   fml_dr = '0;
  logic          fml_ack;
  logic          inv = 1'b0;
  logic          drv_ack = 1'b0;
  logic          zw = 1'b0;
  bit            inv_on_ack = 1'b0;
  int            lat = 5;
  int            n_req = 0;
  int            total = 0;
  int            fails = 0;
  logic [63:0]   last_dw;
  logic [7:0]    last_sel;
  logic          last_we;
  logic [AW-1:0] last_adr;
  logic [63:0]   smem[int];
  logic [63:0]   rmem[int];
  logic [31:0]   exp_q[$];

  always #5 sys_clk = ~sys_clk;
  assign fml_ack = zw ? fml_stb : drv_ack;

  fml_wb_bridge #(.adr_width(AW)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_we_i (wb_we_i),
    .wb_ack_o(wb_ack_o),
    .fml_adr (fml_adr),
    .fml_stb (fml_stb),
    .fml_we  (fml_we),
    .fml_sel (fml_sel),
    .fml_dw  (fml_dw),
    .fml_dr  (fml_dr),
    .fml_ack (fml_ack),
    .inv     (inv)
  );

  function automatic logic [63:0] dflt(input int a);
    logic [31:0] v;
    v = a;
    return {16'hA5A5, v[15:0], 16'h5A5A, v[15:0]};
  endfunction

  function automatic logic [63:0] bmerge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] s);
    for (int i = 0; i < 8; i++) if (s[i]) old[8*i +: 8] = nw[8*i +: 8];
    return old;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] adr);
    int a;
    logic [63:0] w;
    a = int'(adr & 32'hFFFF_FFF8);
    w = rmem.exists(a) ? rmem[a] : dflt(a);
    return adr[2] ? w[31:0] : w[63:32];
  endfunction

  task automatic ref_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int a;
    logic [63:0] old;
    a = int'(adr & 32'hFFFF_FFF8);
    old = rmem.exists(a) ? rmem[a] : dflt(a);
    rmem[a] = bmerge(old, {dat, dat}, adr[2] ? {4'h0, sel} : {sel, 4'h0});
  endtask

  // FML slave: acks after lat cycles of fml_stb (or combinationally when zw), owns its own memory
  initial begin
    int cnt;
    int a;
    cnt = 0;
    forever begin
      @(negedge sys_clk);
      drv_ack = 1'b0;
      inv = 1'b0;
      if (fml_stb && !sys_rst) begin
        cnt++;
        if (zw || cnt >= lat) begin
          a = int'(fml_adr);
          cnt = 0;
          n_req++;
          last_dw = fml_dw;
          last_sel = fml_sel;
          last_we = fml_we;
          last_adr = fml_adr;
          if (fml_we) smem[a] = bmerge(smem.exists(a) ? smem[a] : dflt(a), fml_dw, fml_sel);
          fml_dr = smem.exists(a) ? smem[a] : dflt(a);
          if (!zw) drv_ack = 1'b1;
          if (inv_on_ack) inv = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic xfer(input string tag, input logic [31:0] adr, input logic we, input logic [31:0] dat,
                      input logic [3:0] sel, input int exp_cyc, input int exp_req);
    int cyc_n;
    int req0;
    bit got;
    @(posedge sys_clk); #1;
    wb_adr_i = adr;
    wb_we_i  = we;
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    if (!we) exp_q.push_back(exp_rd(adr));
    else ref_wr(adr, dat, sel);
    req0 = n_req;
    got = 1'b0;
    cyc_n = 0;
    while (!got && cyc_n < 40) begin
      @(posedge sys_clk); #1;
      cyc_n++;
      got = wb_ack_o;
    end
    chk({tag, " ack"}, 64'(got), 64'd1);
    if (got) chk({tag, " latency"}, 64'(cyc_n), 64'(exp_cyc));
    if (!we) begin
      if (got) chk({tag, " data"}, 64'(wb_dat_o), 64'(exp_q.pop_front()));
      else void'(exp_q.pop_front());
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    chk({tag, " fml requests"}, 64'(n_req - req0), 64'(exp_req));
    @(posedge sys_clk); #1;
    chk({tag, " ack single cycle"}, 64'(wb_ack_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int req0;
    int k;
    bit held;
    bit sawack;
    rmem[32'h100] = 64'h11112222_33334444;
    smem[32'h100] = 64'h11112222_33334444;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reset fml_stb", 64'(fml_stb), 64'd0);
    chk("reset fml_we", 64'(fml_we), 64'd0);
    chk("reset wb_ack_o", 64'(wb_ack_o), 64'd0);
    chk("reset fml_sel", 64'(fml_sel), 64'd0);
    chk("reset fml_adr", 64'(fml_adr), 64'd0);
    chk("reset fml_dw", fml_dw, 64'd0);
    chk("reset wb_dat_o", 64'(wb_dat_o), 64'd0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;

    // Miss then hit on the other half of the same FML word
    lat = 5;
    xfer("miss 0x100", 32'h100, 1'b0, 32'h0, 4'hF, 6, 1);
    chk("miss fml_sel", 64'(last_sel), 64'hFF);
    chk("miss fml_adr", 64'(last_adr), 64'h100);
    chk("miss fml_we", 64'(last_we), 64'd0);
    xfer("hit 0x104", 32'h104, 1'b0, 32'h0, 4'hF, 1, 0);

    // Write-through with merge into the buffer
    lat = 2;
    xfer("write 0x104", 32'h104, 1'b1, 32'hAABBCCDD, 4'b0011, 3, 1);
    chk("write fml_sel", 64'(last_sel), 64'h03);
    chk("write fml_dw", last_dw, 64'hAABBCCDD_AABBCCDD);
    chk("write fml_we", 64'(last_we), 64'd1);
    chk("write fml_adr", 64'(last_adr), 64'h100);
    xfer("merged 0x104", 32'h104, 1'b0, 32'h0, 4'hF, 1, 0);
    chk("merged literal", 64'(wb_dat_o), 64'h3333CCDD);
    xfer("write 0x100", 32'h100, 1'b1, 32'h55667788, 4'b1100, 3, 1);
    chk("write hi fml_sel", 64'(last_sel), 64'hC0);
    xfer("merged 0x100", 32'h100, 1'b0, 32'h0, 4'hF, 1, 0);

    // Invalidate in the same cycle as the read fill
    inv_on_ack = 1'b1;
    xfer("inv race", 32'h200, 1'b0, 32'h0, 4'hF, 3, 1);
    inv_on_ack = 1'b0;
    xfer("reread after inv", 32'h200, 1'b0, 32'h0, 4'hF, 3, 1);

    // Abort: master drops cyc two cycles into a read
    lat = 6;
    @(posedge sys_clk); #1;
    wb_adr_i = 32'h300;
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    req0 = n_req;
    repeat (2) @(posedge sys_clk);
    #1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    held = 1'b1;
    sawack = 1'b0;
    k = 0;
    while (n_req == req0 && k < 20) begin
      if (!fml_stb) held = 1'b0;
      if (wb_ack_o) sawack = 1'b1;
      @(posedge sys_clk); #1;
      k++;
    end
    repeat (3) begin
      if (wb_ack_o) sawack = 1'b1;
      @(posedge sys_clk); #1;
    end
    chk("abort fml request", 64'(n_req - req0), 64'd1);
    chk("abort fml_stb held", 64'(held), 64'd1);
    chk("abort no wb_ack", 64'(sawack), 64'd0);
    chk("abort fml_stb released", 64'(fml_stb), 64'd0);
    lat = 2;
    xfer("hit after abort", 32'h300, 1'b0, 32'h0, 4'hF, 1, 0);

    // Zero-wait slave
    zw = 1'b1;
    xfer("zw miss 0x400", 32'h400, 1'b0, 32'h0, 4'hF, 2, 1);
    xfer("zw write 0x404", 32'h404, 1'b1, 32'h0BADF00D, 4'b1111, 2, 1);
    xfer("zw hit 0x404", 32'h404, 1'b0, 32'h0, 4'hF, 1, 0);
    xfer("zw miss 0x408", 32'h408, 1'b0, 32'h0, 4'hF, 2, 1);
    zw = 1'b0;

    // Asynchronous reset in the middle of a read
    xfer("fill 0x500", 32'h500, 1'b0, 32'h0, 4'hF, 3, 1);
    xfer("hit 0x500", 32'h500, 1'b0, 32'h0, 4'hF, 1, 0);
    lat = 8;
    @(posedge sys_clk); #1;
    wb_adr_i = 32'h508;
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    repeat (3) @(posedge sys_clk);
    #3;
    chk("pre-reset fml_stb", 64'(fml_stb), 64'd1);
    sys_rst = 1'b1;
    #1;
    chk("async reset fml_stb", 64'(fml_stb), 64'd0);
    chk("async reset wb_ack_o", 64'(wb_ack_o), 64'd0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    lat = 2;
    xfer("miss after reset", 32'h500, 1'b0, 32'h0, 4'hF, 3, 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/fml_wb_bridge.md
# fml_wb_bridge

Wishbone-to-FML bridge feeding the DDR3 FML slave: converts 32-bit single-beat Wishbone classic cycles from the CPU bus into 64-bit single-beat FML transactions. It keeps a one-entry, 64-bit read buffer so that consecutive reads to the same FML word are served without a DDR3 access. Writes are write-through and update the buffer on a hit. It sits between the system Wishbone interconnect and the FML port of the DDR3 controller top, on `sys_clk`.

## Interface
- `adr_width`, 30: FML byte-address width; must match the DDR3 FML slave.
- `sys_clk`  in  1  system clock (80 MHz); all logic on rising edge.
- `sys_rst`  in  1  reset, asynchronous, active-high.
- `wb_adr_i`  in  32  Wishbone byte address; only `[adr_width-1:2]` is used.
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data; valid only while `wb_ack_o`=1.
- `wb_sel_i`  in  4  byte enables; `[3]` is MSB (big-endian).
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i`  in  1 each  Wishbone classic controls.
- `wb_ack_o`  out  1  one-cycle acknowledge.
- `fml_adr`  out  adr_width  FML byte address; low 3 bits always 0.
- `fml_stb`  out  1  FML request, held until `fml_ack`.
- `fml_we`  out  1  FML write.
- `fml_sel`  out  8  FML byte enables.
- `fml_dw`  out  64  FML write data.
- `fml_dr`  in  64  FML read data, valid in the `fml_ack` cycle.
- `fml_ack`  in  1  FML one-cycle acknowledge.
- `inv`  in  1  single-cycle pulse that invalidates the read buffer.

## Operation
- Lane mapping:
  - `wb_adr_i[2]`=0 selects `fml_dr[63:32]` and `fml_sel[7:4]`.
  - `wb_adr_i[2]`=1 selects `[31:0]` and `[3:0]`.
  - `fml_adr = {wb_adr_i[adr_width-1:3], 3'b000}`.
- Buffer contents: `valid`, `tag` (`adr[adr_width-1:3]`), `data` (64 bits).
- A hit is `valid && tag == wb_adr_i[adr_width-1:3]`.
- FSM states: IDLE, RD, WR, ACK.
  - IDLE, `wb_cyc_i && wb_stb_i`:
    - read hit → ACK, with `wb_dat_o` loaded from the buffer;
    - read miss → RD;
    - write → WR.
  - RD: `fml_stb`=1, `fml_we`=0, `fml_sel`=8'hFF. On `fml_ack`:
    - load the buffer with data and tag;
    - set `valid`;
    - latch `wb_dat_o` from the selected half;
    - → ACK.
  - WR: `fml_stb`=1, `fml_we`=1, `fml_dw={wb_dat_i,wb_dat_i}`, `fml_sel` = `wb_sel_i` placed in the selected half, zeros in the other half. On `fml_ack`:
    - if hit, merge the enabled bytes into the buffer;
    - → ACK.
  - ACK: `wb_ack_o`=1 for exactly one cycle → IDLE.
- `fml_adr`, `fml_we`, `fml_sel` and `fml_dw` are registered when leaving IDLE and stay stable while `fml_stb`=1.
- `inv`: clears `valid` next cycle.
  - `inv` together with the RD `fml_ack`: the read completes and data is returned, but `valid` ends at 0.
  - `inv` wins over a write merge.
- Abort: if `wb_cyc_i` drops during RD/WR, the FML transaction still completes and the buffer update still occurs. The FSM goes to IDLE instead of ACK, and no `wb_ack_o` is issued.
- Reset (any state, async):
  - state=IDLE; `valid`=0;
  - `fml_stb`=`fml_we`=`wb_ack_o`=0;
  - `fml_sel`, `fml_adr`, `fml_dw`, `wb_dat_o` = 0.
  - The FML slave must be reset together with the bridge.

## Timing
- Read hit: `stb` sampled in IDLE at cycle 0 → `wb_ack_o`=1 at cycle 1.
- Read miss / write: `stb` at cycle 0 → `fml_stb`=1 from cycle 1. `fml_ack` at cycle N → `fml_stb`=0 and `wb_ack_o`=1 at N+1.
- `fml_ack` in the same cycle `fml_stb` first rises is legal; then N=1 and `wb_ack_o` comes at cycle 2.
- Next request: the earliest is sampled in IDLE at cycle ack+1, so the bridge needs at least one idle cycle between Wishbone transactions. The master must deassert `stb` or present a new request in that cycle.
- `fml_ack` seen outside RD/WR is ignored.

## Structure
- Package `fml_wb_bridge_pkg` holds:
  - state encoding (IDLE=0, RD=1, WR=2, ACK=3);
  - the `LANE_HI`=0 constant for the `wb_adr_i[2]` mapping.
- Sub-module `fml_wb_merge` is combinational. Inputs: 64-bit old data, 32-bit new data, 4-bit sel, lane. Outputs: merged 64-bit data and 8-bit `fml_sel`. It is shared by the WR `fml_sel` generation and the buffer merge.

## Test plan
- Read miss then hit:
  - read `0x100` with FML returning `0x11112222_33334444` after 5 cycles → `wb_dat_o`=`0x11112222`;
  - then read `0x104` → ack at cycle 1, `0x33334444`, no `fml_stb`.
- Write hit merge: after the buffer is filled, write `0x104` data `0xAABBCCDD` with sel `4'b0011` → `fml_sel`=`8'h03`; a subsequent read of `0x104` hits and returns `0x3333CCDD`.
- Invalidate race: assert `inv` in the same cycle as the RD `fml_ack` → data returned; an immediate re-read of the same address issues `fml_stb`.
- Abort: drop `wb_cyc_i` 2 cycles into RD → `fml_stb` held until `fml_ack`, no `wb_ack_o`, FSM back in IDLE.
- Zero-wait slave: `fml_ack` tied to `fml_stb` → each miss is acked at cycle 2 and each transaction issues exactly one FML request.
- Async reset mid-RD → `fml_stb` and `valid` low immediately; the next read of the previous address misses.
